// File: rtl/note_sequencer2.sv
// Player-2 note chart generator and play-out tracker: fills a chart of one-hot
// lanes from a 16-bit LFSR, then scores key-press events row by row.
module note_sequencer2 #(
    parameter int          DEPTH = 100,
    parameter logic [15:0] SEED  = 16'hACE1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        start,
    input  logic [15:0] keycode,
    input  logic        correct_key2,
    output logic [2:0]  random_array2 [0:DEPTH-1],
    output logic [31:0] row_counter2,
    output logic [7:0]  score,
    output logic [7:0]  misses,
    output logic        busy,
    output logic        done
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_PLAY, S_DONE} state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [15:0]     r_lfsr;
    logic [IW-1:0]   r_idx;
    logic            r_prev_idle;
    logic [31:0]     r_row;
    logic [7:0]      r_score;
    logic [7:0]      r_misses;
    logic [2:0]      r_chart [0:DEPTH-1];

    logic            w_key_idle;
    logic            w_press;
    logic            w_fill_we;
    logic            w_play_ev;
    logic            w_restart;
    logic            w_last_idx;
    logic            w_last_row;
    logic            w_fb;
    logic [2:0]      w_lane;

    assign w_key_idle = (keycode == 16'h0000) || (keycode == 16'h0520);
    assign w_press    = r_prev_idle && !w_key_idle;
    assign w_last_idx = (r_idx == IW'(DEPTH - 1));
    assign w_last_row = (r_row == 32'(DEPTH - 1));
    assign w_fb       = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

    // Two LFSR codes map to the middle lane, so middle notes appear twice as often.
    always_comb begin
        case (r_lfsr[1:0])
            2'b00:   w_lane = 3'b100;
            2'b01:   w_lane = 3'b010;
            2'b10:   w_lane = 3'b001;
            default: w_lane = 3'b010;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (start)                  w_state_next = S_FILL;
            S_FILL:         if (w_last_idx)             w_state_next = S_PLAY;
            S_PLAY:         if (w_press && w_last_row)  w_state_next = S_DONE;
            default:                                    w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (r_state == S_FILL) || (r_state == S_PLAY);
        done      = (r_state == S_DONE);
        w_fill_we = (r_state == S_FILL);
        w_play_ev = (r_state == S_PLAY) && w_press;
        w_restart = ((r_state == S_IDLE) || (r_state == S_DONE)) && start;
    end

    // The LFSR is deliberately not reloaded on restart so each new chart differs.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_lfsr      <= SEED;
            r_idx       <= '0;
            r_prev_idle <= 1'b1;
            r_row       <= '0;
            r_score     <= '0;
            r_misses    <= '0;
        end else begin
            r_prev_idle <= w_key_idle;
            if (w_restart) begin
                r_idx    <= '0;
                r_row    <= '0;
                r_score  <= '0;
                r_misses <= '0;
            end
            if (w_fill_we) begin
                r_lfsr <= {r_lfsr[14:0], w_fb};
                r_idx  <= r_idx + 1'b1;
            end
            if (w_play_ev) begin
                if (correct_key2) begin
                    if (r_score != 8'hFF) r_score <= r_score + 8'd1;
                end else begin
                    if (r_misses != 8'hFF) r_misses <= r_misses + 8'd1;
                end
                if (!w_last_row) r_row <= r_row + 32'd1;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) r_chart[i] <= 3'b000;
        end else if (w_fill_we) begin
            r_chart[r_idx] <= w_lane;
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_out
        assign random_array2[gi] = r_chart[gi];
    end

    assign row_counter2 = r_row;
    assign score        = r_score;
    assign misses       = r_misses;

endmodule

// File: tb/tb_note_sequencer2.sv
// Randomized bench for note_sequencer2 against a behavioural chart/score model.
module tb_note_sequencer2;

    localparam int          DEPTH = 300;
    localparam logic [15:0] SEED  = 16'hACE1;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        start;
    logic [15:0] keycode;
    logic        correct_key2;
    logic [2:0]  random_array2 [0:DEPTH-1];
    logic [31:0] row_counter2;
    logic [7:0]  score;
    logic [7:0]  misses;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_errors = 0;

    note_sequencer2 #(.DEPTH(DEPTH), .SEED(SEED)) u_dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .start        (start),
        .keycode      (keycode),
        .correct_key2 (correct_key2),
        .random_array2(random_array2),
        .row_counter2 (row_counter2),
        .score        (score),
        .misses       (misses),
        .busy         (busy),
        .done         (done)
    );

    always #5 Clk = ~Clk;

    // Reference model state
    logic [15:0] m_lfsr;
    int          m_fill_left;
    bit          m_play;
    bit          m_done;
    int          m_row;
    int          m_score;
    int          m_misses;
    logic [15:0] m_prev_key;
    logic [2:0]  m_chart [DEPTH];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit key_idle(input logic [15:0] k);
        return (k == 16'h0000) || (k == 16'h0520);
    endfunction

    function automatic logic [2:0] lane_of(input logic [15:0] l);
        case (l % 4)
            0:       return 3'b100;
            1:       return 3'b010;
            2:       return 3'b001;
            default: return 3'b010;
        endcase
    endfunction

    task automatic model_reset();
        m_lfsr      = SEED;
        m_fill_left = 0;
        m_play      = 0;
        m_done      = 0;
        m_row       = 0;
        m_score     = 0;
        m_misses    = 0;
        m_prev_key  = 16'h0000;
        for (int i = 0; i < DEPTH; i++) m_chart[i] = 3'b000;
    endtask

    task automatic model_edge();
        bit ev;
        if (Reset) begin
            model_reset();
            return;
        end
        ev = key_idle(m_prev_key) && !key_idle(keycode);
        if (m_fill_left > 0) begin
            m_chart[DEPTH - m_fill_left] = lane_of(m_lfsr);
            m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
            m_fill_left--;
            if (m_fill_left == 0) m_play = 1;
        end else if (m_play) begin
            if (ev) begin
                if (correct_key2) m_score  = (m_score  < 255) ? m_score + 1  : 255;
                else              m_misses = (m_misses < 255) ? m_misses + 1 : 255;
                if (m_row == DEPTH - 1) begin
                    m_play = 0;
                    m_done = 1;
                end else begin
                    m_row++;
                end
            end
        end else if (start) begin
            m_fill_left = DEPTH;
            m_row       = 0;
            m_score     = 0;
            m_misses    = 0;
            m_done      = 0;
        end
        m_prev_key = keycode;
    endtask

    task automatic check_outputs(input string ph);
        check_val({ph, "_row"},    row_counter2, 32'(m_row));
        check_val({ph, "_score"},  {24'd0, score},  32'(m_score));
        check_val({ph, "_misses"}, {24'd0, misses}, 32'(m_misses));
        check_val({ph, "_busy"},   {31'd0, busy},   {31'd0, (m_fill_left > 0) || m_play});
        check_val({ph, "_done"},   {31'd0, done},   {31'd0, m_done});
    endtask

    task automatic check_chart(input string ph);
        for (int i = 0; i < DEPTH; i++)
            check_val($sformatf("%s_chart%0d", ph, i), {29'd0, random_array2[i]}, {29'd0, m_chart[i]});
    endtask

    task automatic step(input string ph);
        @(posedge Clk);
        model_edge();
        @(negedge Clk);
        check_outputs(ph);
    endtask

    task automatic rand_inputs(input bit allow_start);
        case ($urandom % 6)
            0:       keycode = 16'h0000;
            1:       keycode = 16'h0520;
            2:       keycode = 16'h000e;
            3:       keycode = 16'h0e04;
            4:       keycode = 16'h000d;
            default: keycode = 16'($urandom);
        endcase
        correct_key2 = (($urandom % 20) != 0);
        start        = allow_start && (($urandom % 50) == 0);
    endtask

    initial begin
        int cyc;
        Reset = 1'b1; start = 1'b0; keycode = 16'h0000; correct_key2 = 1'b0;
        model_reset();
        repeat (2) step("rst");
        check_chart("rst");
        Reset = 1'b0;

        // First fill from SEED
        start = 1'b1;
        step("start");
        start = 1'b0;
        repeat (DEPTH) step("fill");
        check_chart("fill1");
        check_val("seed_lane0", {29'd0, random_array2[0]}, 32'd2);
        check_val("seed_lane1", {29'd0, random_array2[1]}, 32'd2);
        check_val("seed_lane2", {29'd0, random_array2[2]}, 32'd2);
        $display("fill1 complete: busy=%0b row=%0d", busy, row_counter2);

        // Random play through to the last row
        cyc = 0;
        while (!m_done && cyc < 20000) begin
            rand_inputs(m_play);
            step("play");
            cyc++;
        end
        check_val("play_reached_done", {31'd0, done}, 32'd1);
        check_val("score_saturated", {24'd0, score}, 32'd255);
        $display("play1 ended after %0d cycles: score=%0d misses=%0d", cyc, score, misses);

        // Presses after DONE change nothing
        repeat (30) begin
            rand_inputs(1'b0);
            step("done_hold");
        end

        // Restart, then asynchronous reset partway through the fill
        keycode = 16'h0000; correct_key2 = 1'b0;
        start = 1'b1;
        step("restart");
        start = 1'b0;
        repeat (37) step("fill2");
        check_chart("fill2_partial");
        Reset = 1'b1;
        #1;
        model_reset();
        check_outputs("async_rst");
        check_chart("async_rst");
        $display("async reset mid-fill: busy=%0b row=%0d", busy, row_counter2);
        step("rst2");
        Reset = 1'b0;

        // Fill again from SEED after reset, then a short play stretch
        start = 1'b1;
        step("start3");
        start = 1'b0;
        repeat (DEPTH) step("fill3");
        check_chart("fill3");
        check_val("seed3_lane0", {29'd0, random_array2[0]}, 32'd2);
        repeat (200) begin
            rand_inputs(m_play);
            step("play3");
        end
        $display("play3 stretch: row=%0d score=%0d misses=%0d", row_counter2, score, misses);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/note_sequencer2.md
# note_sequencer2

Generates and plays out the player-2 note chart for the rhythm game. On `start` it fills a DEPTH-entry array of one-hot lane codes from a 16-bit LFSR, one entry per clock. During play it detects key-press events on the USB keycode and advances the row pointer on each press. It tallies hits and misses using the combinational hit flag returned by the player-2 key checker for the current row. It drives that checker's `random_array2` and `row_counter2` inputs and consumes its `correct_key2` output.

## Interface
- `DEPTH`, 100: number of chart rows; must be ≥ 2.
- `SEED`, 16'hACE1: LFSR reset value; must be nonzero.

- `Clk`  in  1  system clock; all state changes on the rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle request; sampled only in IDLE and DONE.
- `keycode`  in  16  two-slot keycode from the USB keyboard interface.
- `correct_key2`  in  1  hit flag from the checker for the current `row_counter2`.
- `random_array2`  out  3 × DEPTH  chart rows, each 3'b100 (left), 3'b010 (middle) or 3'b001 (right); 3'b000 means unfilled.
- `row_counter2`  out  integer (32)  current row index, range 0..DEPTH-1.
- `score`  out  8  hit count, saturating at 255.
- `misses`  out  8  miss count, saturating at 255.
- `busy`  out  1  high in FILL and PLAY.
- `done`  out  1  high in DONE.

## Operation
- Reset values:
  - all `random_array2` entries are 3'b000.
  - `row_counter2`, `score`, `misses`, `busy` and `done` are 0.
  - LFSR = SEED, `prev_idle` = 1, state = IDLE.
- LFSR is a Fibonacci LFSR.
  - fb = l[15]^l[13]^l[12]^l[10]; next = {l[14:0], fb}.
  - It shifts only on FILL write cycles.
  - It is not reloaded on `start`, so successive charts differ.
- Lane mapping from l[1:0]: 00→3'b100, 01→3'b010, 10→3'b001, 11→3'b010.
- Idle keycodes are 16'h0000 and 16'h0520. Any other value is a non-idle keycode.
- `prev_idle` is a registered flag holding whether the previous cycle's keycode was idle.
- A press event occurs in a cycle where `prev_idle` = 1 and the current keycode is non-idle. Holding a key or changing from one non-idle keycode to another is not a new event.
- State IDLE: `start` → FILL. On that transition `row_counter2`, `score` and `misses` clear, and the write index clears to 0.
- State FILL: each cycle writes `random_array2[idx]` from the current LFSR, shifts the LFSR, and increments idx.
  - After writing idx = DEPTH-1 → PLAY.
  - Key events during FILL are ignored, but `prev_idle` keeps tracking the keycode.
- State PLAY, on each press event:
  - if `correct_key2` = 1, `score`++; otherwise `misses`++. Both counters saturate.
  - if `row_counter2` < DEPTH-1, `row_counter2`++; if it equals DEPTH-1, the counter holds and the state goes → DONE.
- State DONE: outputs hold. `start` → FILL, with the same clears as from IDLE.
- `start` during FILL or PLAY is ignored.
- Reset asserted mid-operation returns everything to reset values immediately; a partial chart is zeroed.

## Timing
- `start` at edge N puts the block in FILL. Entry k is written at edge N+1+k.
- PLAY begins after edge N+DEPTH: `busy` = 1 from edge N, and the state is PLAY from edge N+DEPTH.
- `correct_key2` is sampled in the same cycle as the press event. The checker is combinational from the current `row_counter2`, so there is no pipeline skew.
- `row_counter2`, `score` and `misses` update one edge after the event cycle.
- A press event at most once per key-down. The minimum event spacing is 2 cycles, one idle cycle between presses.
- `done` rises on the edge that scores the last row. `busy` falls on the same edge.

## Test plan
- Reset then `start` with SEED = 16'hACE1 → entries 0, 1 and 2 = 3'b010 and LFSR = 16'h670F after the third write. `busy` = 1 throughout the fill, and PLAY is reached after 100 writes.
- In PLAY, row 0 = 3'b010: drive keycode 0000 → 000e with `correct_key2` = 1 → `score` = 1, `misses` = 0, `row_counter2` = 1 on the next edge.
- Hold keycode 000e for 10 cycles, then go to 0e04 → no further events, and `row_counter2` stays at 1. Then drive 0520 followed by 000d with `correct_key2` = 0 → `misses` = 1 and `row_counter2` = 2.
- DEPTH = 4: perform 4 presses → `row_counter2` = 3, `done` = 1, `busy` = 0. A fifth press changes nothing. `start` clears the counters and refills with new LFSR data.
- Assert `Reset` asynchronously mid-FILL at idx = 37 → all outputs return to reset values before the next clock edge, and the array reads all 3'b000.
- Force `score` to 255 via a long hit run with DEPTH = 300 → `score` holds at 255 while `row_counter2` continues to advance.
